// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
// Access controller between two RAM clients and a 64x8 true dual-port RAM.
// Requester 0 drives RAM port A, requester 1 drives RAM port B.
// A same-address access pair in which at least one side writes is a conflict.
// The requester picked by a round-robin priority bit proceeds, and the other
// requester is held off for that cycle. Traffic with no conflict passes
// through with no added latency.
//
// Handshake: reqN is raised with weN/addrN/wdataN stable and stays high until
// gntN is seen high. gntN is combinational. The access completes at the next
// rising edge. A granted read returns rvalidN/rdataN one cycle later. A write
// has no completion signal other than gntN.
module dpram_port_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_a,
  output logic [DW-1:0] ram_data_b,
  output logic          ram_we_a,
  output logic          ram_we_b,
  input  logic [DW-1:0] ram_q_a,
  input  logic [DW-1:0] ram_q_b,
  output logic [CW-1:0] conflict_cnt
);

  // Priority bit: 0 favours requester 0 and 1 favours requester 1.
  logic          r_prio;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [CW-1:0] r_conflict_cnt;

  logic          w_conflict;
  logic          w_gnt0;
  logic          w_gnt1;

  // A collision needs both requests on the same address with at least one
  // write. Two reads of the same cell are not a collision.
  assign w_conflict = req0 & req1 & (addr0 == addr1) & (we0 | we1);

  // Grant decode. Both grants are forced low during reset, so no write can
  // reach the RAM while rst is high.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (w_conflict) begin
        w_gnt0 = ~r_prio;
        w_gnt1 = r_prio;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;

  // RAM ports follow their requesters directly. An ungranted or idle port
  // only performs a harmless read.
  assign ram_addr_a = addr0;
  assign ram_addr_b = addr1;
  assign ram_data_a = wdata0;
  assign ram_data_b = wdata1;
  assign ram_we_a   = req0 & w_gnt0 & we0;
  assign ram_we_b   = req1 & w_gnt1 & we1;

  // Read data comes straight from the registered RAM outputs.
  assign rdata0  = ram_q_a;
  assign rdata1  = ram_q_b;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;

  assign conflict_cnt = r_conflict_cnt;

  // Round-robin update: on a collision, the priority moves to the loser,
  // which is always the side not currently favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_conflict) begin
      r_prio <= ~r_prio;
    end
  end

  // Read-valid flags line up with the RAM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= req0 & w_gnt0 & ~we0;
      r_rvalid1 <= req1 & w_gnt1 & ~we1;
    end
  end

  // Saturating collision counter. It holds at all-ones and never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != {CW{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: directed traffic against a behavioural
// dual-port RAM, with read data checked through expected queues.
module tb_dpram_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- main DUT (CW = 16) ----------------
  logic       req0, we0, req1, we1;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [5:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_data_a, ram_data_b;
  logic       ram_we_a, ram_we_b;
  logic [7:0] ram_q_a, ram_q_b;
  logic [15:0] conflict_cnt;

  dpram_port_arbiter #(.AW(6), .DW(8), .CW(16)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b),
    .conflict_cnt(conflict_cnt)
  );

  // Behavioural 64x8 true dual-port RAM with registered outputs.
  logic [7:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    ram_q_a <= mem[ram_addr_a];
    ram_q_b <= mem[ram_addr_b];
  end

  // ---------------- saturation DUT (CW = 2) ----------------
  logic       s_req0, s_we0, s_req1, s_we1;
  logic [5:0] s_addr0, s_addr1;
  logic [7:0] s_wdata0, s_wdata1;
  logic       s_gnt0, s_gnt1, s_rvalid0, s_rvalid1;
  logic [7:0] s_rdata0, s_rdata1;
  logic [5:0] s_ram_addr_a, s_ram_addr_b;
  logic [7:0] s_ram_data_a, s_ram_data_b;
  logic       s_ram_we_a, s_ram_we_b;
  logic [7:0] s_ram_q_a, s_ram_q_b;
  logic [1:0] s_cnt;

  assign s_ram_q_a = 8'h00;
  assign s_ram_q_b = 8'h00;

  dpram_port_arbiter #(.AW(6), .DW(8), .CW(2)) u_sat (
    .clk(clk), .rst(rst),
    .req0(s_req0), .we0(s_we0), .addr0(s_addr0), .wdata0(s_wdata0),
    .req1(s_req1), .we1(s_we1), .addr1(s_addr1), .wdata1(s_wdata1),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .rvalid0(s_rvalid0), .rvalid1(s_rvalid1),
    .rdata0(s_rdata0), .rdata1(s_rdata1),
    .ram_addr_a(s_ram_addr_a), .ram_addr_b(s_ram_addr_b),
    .ram_data_a(s_ram_data_a), .ram_data_b(s_ram_data_b),
    .ram_we_a(s_ram_we_a), .ram_we_b(s_ram_we_b),
    .ram_q_a(s_ram_q_a), .ram_q_b(s_ram_q_b),
    .conflict_cnt(s_cnt)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  int         exp0_c[$];
  int         exp1_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Monitor: whenever a read-valid shows up, pop the expected data and the
  // cycle in which it was due.
  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      if (exp0_q.size() == 0) chk("rvalid0_unexpected", 32'd1, 32'd0);
      else begin
        chk("rdata0", {24'd0, rdata0}, {24'd0, exp0_q.pop_front()});
        chk("rvalid0_latency", cyc_n, exp0_c.pop_front());
      end
    end
    if (rvalid1 === 1'b1) begin
      if (exp1_q.size() == 0) chk("rvalid1_unexpected", 32'd1, 32'd0);
      else begin
        chk("rdata1", {24'd0, rdata1}, {24'd0, exp1_q.pop_front()});
        chk("rvalid1_latency", cyc_n, exp1_c.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Drives one cycle of requests and checks the combinational grants and
  // write enables against hand-computed values. Expected read data for a
  // granted read is queued for the monitor.
  task automatic cyc(input logic r0, input logic w0, input logic [5:0] a0, input logic [7:0] d0,
                     input logic r1, input logic w1, input logic [5:0] a1, input logic [7:0] d1,
                     input logic eg0, input logic eg1,
                     input logic [7:0] er0, input logic [7:0] er1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
    chk("gnt0", {31'd0, gnt0}, {31'd0, eg0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, eg1});
    chk("ram_we_a", {31'd0, ram_we_a}, {31'd0, eg0 & r0 & w0});
    chk("ram_we_b", {31'd0, ram_we_b}, {31'd0, eg1 & r1 & w1});
    if (eg0 && r0 && !w0) begin exp0_q.push_back(er0); exp0_c.push_back(cyc_n + 1); end
    if (eg1 && r1 && !w1) begin exp1_q.push_back(er1); exp1_c.push_back(cyc_n + 1); end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask

  logic [1:0] sat_exp [5];

  initial begin
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    s_req0 = 0; s_we0 = 0; s_addr0 = 0; s_wdata0 = 0;
    s_req1 = 0; s_we1 = 0; s_addr1 = 0; s_wdata1 = 0;
    @(posedge clk); #1;

    // Reset: colliding writes are held off and nothing is written.
    cyc(1, 1, 6'd3, 8'hEE, 1, 1, 6'd3, 8'hDD, 0, 0, 8'h00, 8'h00);
    cyc(1, 0, 6'd3, 8'h00, 1, 0, 6'd5, 8'h00, 0, 0, 8'h00, 8'h00);
    chk("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
    rst = 1'b0;

    // Independent traffic, both granted in the same cycle.
    cyc(1, 1, 6'd3, 8'h11, 1, 1, 6'd5, 8'h22, 1, 1, 8'h00, 8'h00);
    cyc(1, 0, 6'd3, 8'h00, 1, 0, 6'd5, 8'h00, 1, 1, 8'h11, 8'h22);
    idle();
    chk("indep_cnt", {16'd0, conflict_cnt}, 32'd0);

    // Write/write collision on addr 7: 0 wins, 1 follows, and 0x55 remains.
    cyc(1, 1, 6'd7, 8'hAA, 1, 1, 6'd7, 8'h55, 1, 0, 8'h00, 8'h00);
    cyc(0, 0, 6'd0, 8'h00, 1, 1, 6'd7, 8'h55, 0, 1, 8'h00, 8'h00);
    cyc(1, 0, 6'd7, 8'h00, 0, 0, 6'd0, 8'h00, 1, 0, 8'h55, 8'h00);
    idle();
    chk("ww_cnt", {16'd0, conflict_cnt}, 32'd1);

    // Sustained contention from a fresh reset: grants alternate 0,1,0,1,0,1.
    rst = 1'b1;
    idle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 6'd9, 8'h90 + 8'(i), 1, 1, 6'd9, 8'hA0 + 8'(i),
          (i % 2) == 0, (i % 2) == 1, 8'h00, 8'h00);
    end
    chk("sustain_cnt", {16'd0, conflict_cnt}, 32'd6);

    // Give requester 1 the priority so that a collision is won by 1.
    cyc(1, 1, 6'd10, 8'h01, 1, 1, 6'd10, 8'h02, 1, 0, 8'h00, 8'h00);
    cyc(0, 0, 6'd0, 8'h00, 1, 1, 6'd10, 8'h02, 0, 1, 8'h00, 8'h00);
    // Write/read collision: the read on 1 wins and sees old 0x00, then the write lands.
    cyc(1, 1, 6'd4, 8'h3C, 1, 0, 6'd4, 8'h00, 0, 1, 8'h00, 8'h00);
    cyc(1, 1, 6'd4, 8'h3C, 0, 0, 6'd0, 8'h00, 1, 0, 8'h00, 8'h00);
    cyc(0, 0, 6'd0, 8'h00, 1, 0, 6'd4, 8'h00, 0, 1, 8'h00, 8'h3C);
    idle();
    chk("wr_cnt", {16'd0, conflict_cnt}, 32'd8);

    // Same-address dual read: both granted, no conflict counted.
    cyc(1, 1, 6'd2, 8'h77, 0, 0, 6'd0, 8'h00, 1, 0, 8'h00, 8'h00);
    cyc(1, 0, 6'd2, 8'h00, 1, 0, 6'd2, 8'h00, 1, 1, 8'h77, 8'h77);
    idle();
    chk("rr_cnt", {16'd0, conflict_cnt}, 32'd8);

    // Move priority to 1, then reset mid-operation with a read pending.
    cyc(1, 1, 6'd12, 8'h01, 1, 1, 6'd12, 8'h02, 1, 0, 8'h00, 8'h00);
    chk("pre_rst_cnt", {16'd0, conflict_cnt}, 32'd9);
    rst = 1'b1;
    cyc(1, 0, 6'd2, 8'h00, 0, 0, 6'd0, 8'h00, 0, 0, 8'h00, 8'h00);
    cyc(1, 1, 6'd5, 8'hFF, 1, 1, 6'd5, 8'hEE, 0, 0, 8'h00, 8'h00);
    rst = 1'b0;
    idle();
    chk("midrst_cnt", {16'd0, conflict_cnt}, 32'd0);
    // The priority is back to 0, so requester 0 wins the next collision.
    cyc(1, 1, 6'd13, 8'h01, 1, 1, 6'd13, 8'h02, 1, 0, 8'h00, 8'h00);
    chk("post_rst_cnt", {16'd0, conflict_cnt}, 32'd1);
    chk("reset_kept_mem5", {24'd0, mem[5]}, 32'h22);

    // Saturation with CW = 2: five collisions, and the count holds at 3.
    for (int i = 0; i < 5; i++) begin
      s_req0 = 1; s_we0 = 1; s_addr0 = 6'd1; s_wdata0 = 8'h10 + 8'(i);
      s_req1 = 1; s_we1 = 1; s_addr1 = 6'd1; s_wdata1 = 8'h20 + 8'(i);
      @(negedge clk);
      chk("sat_gnt0", {31'd0, s_gnt0}, {31'd0, (i % 2) == 0});
      chk("sat_gnt1", {31'd0, s_gnt1}, {31'd0, (i % 2) == 1});
      @(posedge clk); #1;
      chk("sat_cnt", {30'd0, s_cnt}, {30'd0, sat_exp[i]});
    end
    s_req0 = 0; s_req1 = 0;
    idle();
    idle();

    chk("exp0_drained", exp0_q.size(), 32'd0);
    chk("exp1_drained", exp1_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
